cu_seq: RTL and testbench

CU_SEQ -- requirements
Module: cu_seq

---
 rtl/cu_seq.sv | 164 ++++++++++++++++
 tb/tb_cu_seq.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cu_seq.sv
// rtl/cu_seq.sv - control-unit sequencer: fetch/execute FSM with memory wait and multi-cycle shift loop
module cu_seq #(
  parameter int RAW     = 3,
  parameter int USE_RDY = 1,
  localparam int IW     = 7 + 3 * RAW,
  localparam int RSW    = 3 * (RAW + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [IW-1:0]  ins_in,
  input  logic           z_in,
  input  logic           n_in,
  input  logic           mem_rdy_in,
  input  logic           run_in,
  output logic           il_out,
  output logic           rw_out,
  output logic           mm_out,
  output logic           mb_out,
  output logic           iom_out,
  output logic [1:0]     ps_out,
  output logic [RSW-1:0] rs_out,
  output logic [1:0]     md_out,
  output logic [3:0]     fs_out,
  output logic           wen_out,
  output logic           halted_out,
  output logic           illegal_out
);

  localparam logic [6:0] OP_LDI  = 7'h10;
  localparam logic [6:0] OP_ADI  = 7'h11;
  localparam logic [6:0] OP_LD   = 7'h12;
  localparam logic [6:0] OP_ST   = 7'h13;
  localparam logic [6:0] OP_BRZ  = 7'h14;
  localparam logic [6:0] OP_BRN  = 7'h15;
  localparam logic [6:0] OP_JMP  = 7'h16;
  localparam logic [6:0] OP_IOR  = 7'h17;
  localparam logic [6:0] OP_IOW  = 7'h18;
  localparam logic [6:0] OP_SHLN = 7'h19;
  localparam logic [6:0] OP_SHRN = 7'h1A;
  localparam logic [6:0] OP_HAL  = 7'h1B;

  typedef enum logic [2:0] {
    S_RST = 3'd0,
    S_INF = 3'd1,
    S_EX0 = 3'd2,
    S_XLP = 3'd3,
    S_HLT = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [RAW-1:0]   cnt, cnt_nxt;

  logic [6:0]       opc;
  logic [RAW-1:0]   da, aa, ba;
  logic             rdy;
  logic             mem_op;
  logic [3:0]       shift_fs;

  assign opc      = ins_in[IW-1 -: 7];
  assign da       = ins_in[3*RAW-1 -: RAW];
  assign aa       = ins_in[2*RAW-1 -: RAW];
  assign ba       = ins_in[RAW-1:0];
  assign rdy      = (USE_RDY != 0) ? mem_rdy_in : 1'b1;
  assign mem_op   = (opc == OP_LD) || (opc == OP_ST) || (opc == OP_IOR) || (opc == OP_IOW);
  assign shift_fs = (opc == OP_SHLN) ? 4'b1110 : 4'b1101;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_RST;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    il_out      = 1'b0;
    rw_out      = 1'b0;
    mm_out      = 1'b0;
    mb_out      = 1'b0;
    iom_out     = 1'b0;
    ps_out      = 2'b00;
    rs_out      = '0;
    md_out      = 2'b00;
    fs_out      = 4'b0000;
    wen_out     = 1'b1;
    halted_out  = 1'b0;
    illegal_out = 1'b0;

    case (state)
      S_RST: state_nxt = S_INF;

      S_INF: begin
        il_out    = 1'b1;
        mm_out    = 1'b1;
        state_nxt = S_EX0;
      end

      S_EX0: begin
        rs_out    = {1'b0, da, 1'b0, aa, 1'b0, ba};
        ps_out    = 2'b01;
        state_nxt = S_INF;
        if (opc <= 7'h0F) begin
          rw_out = 1'b1;
          fs_out = opc[3:0];
        end else begin
          case (opc)
            OP_LDI: begin rw_out = 1'b1; mb_out = 1'b1; fs_out = 4'b1100; end
            OP_ADI: begin rw_out = 1'b1; mb_out = 1'b1; fs_out = 4'b0010; end
            OP_LD:  begin rw_out = 1'b1; md_out = 2'b01; end
            OP_ST:  wen_out = 1'b0;
            OP_IOR: begin rw_out = 1'b1; md_out = 2'b10; iom_out = 1'b1; end
            OP_IOW: begin wen_out = 1'b0; iom_out = 1'b1; end
            OP_BRZ: begin md_out = 2'b01; ps_out = z_in ? 2'b10 : 2'b01; end
            OP_BRN: begin md_out = 2'b01; ps_out = n_in ? 2'b10 : 2'b01; end
            OP_JMP: ps_out = 2'b11;
            OP_SHLN, OP_SHRN: begin
              fs_out = shift_fs;
              if (ba != '0) rw_out = 1'b1;
              // Shifts wider than one place spill the remaining writes into XLP
              if (ba != '0 && ba != RAW'(1)) begin
                ps_out    = 2'b00;
                cnt_nxt   = ba - RAW'(1);
                state_nxt = S_XLP;
              end
            end
            OP_HAL: state_nxt = S_HLT;
            default: illegal_out = 1'b1;
          endcase
          // Memory/IO not ready: park in EX0 with PC held and both write strobes off
          if (mem_op && !rdy) begin
            ps_out    = 2'b00;
            rw_out    = 1'b0;
            wen_out   = 1'b1;
            state_nxt = S_EX0;
          end
        end
      end

      S_XLP: begin
        rw_out  = 1'b1;
        rs_out  = {1'b0, da, 1'b0, da, {(RAW + 1){1'b0}}};
        fs_out  = shift_fs;
        cnt_nxt = cnt - RAW'(1);
        if (cnt <= RAW'(1)) begin
          ps_out    = 2'b01;
          cnt_nxt   = '0;
          state_nxt = S_INF;
        end
      end

      S_HLT: begin
        halted_out = 1'b1;
        if (run_in) state_nxt = S_INF;
      end

      default: state_nxt = S_RST;
    endcase
  end

endmodule

// File: tb/tb_cu_seq.sv
// tb/tb_cu_seq.sv - directed self-checking bench for cu_seq
module tb_cu_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ins_in;
  logic        z_in, n_in, mem_rdy_in, run_in;
  logic        il_out, rw_out, mm_out, mb_out, iom_out;
  logic [1:0]  ps_out, md_out;
  logic [11:0] rs_out;
  logic [3:0]  fs_out;
  logic        wen_out, halted_out, illegal_out;

  int checks = 0;
  int errors = 0;
  logic [27:0] ex;

  cu_seq #(.RAW(3), .USE_RDY(1)) dut (
    .clk(clk), .rst_n(rst_n), .ins_in(ins_in), .z_in(z_in), .n_in(n_in),
    .mem_rdy_in(mem_rdy_in), .run_in(run_in), .il_out(il_out), .rw_out(rw_out),
    .mm_out(mm_out), .mb_out(mb_out), .iom_out(iom_out), .ps_out(ps_out),
    .rs_out(rs_out), .md_out(md_out), .fs_out(fs_out), .wen_out(wen_out),
    .halted_out(halted_out), .illegal_out(illegal_out)
  );

  always #5 clk = ~clk;

  function automatic logic [27:0] ov();
    return {ps_out, il_out, rw_out, mm_out, mb_out, iom_out, md_out, fs_out,
            wen_out, halted_out, illegal_out, rs_out};
  endfunction

  function automatic logic [27:0] e(logic [1:0] ps, logic il, logic rw, logic mm, logic mb,
                                    logic iom, logic [1:0] md, logic [3:0] fs, logic wen,
                                    logic hlt, logic ill, logic [11:0] rs);
    return {ps, il, rw, mm, mb, iom, md, fs, wen, hlt, ill, rs};
  endfunction

  function automatic logic [11:0] rsf(logic [2:0] da, logic [2:0] aa, logic [2:0] ba);
    return {1'b0, da, 1'b0, aa, 1'b0, ba};
  endfunction

  function automatic logic [15:0] mk(logic [6:0] op, logic [2:0] da, logic [2:0] aa, logic [2:0] ba);
    return {op, da, aa, ba};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ins_in = mk(7'h02, 3'd1, 3'd2, 3'd3);
    z_in = 0; n_in = 0; mem_rdy_in = 1; run_in = 0;
    tick(); tick();
    ex = e(2'b00,0,0,0,0,0,2'b00,4'h0,1,0,0,12'h000);
    checks++; if (ov() !== ex) begin errors++; $display("FAIL reset_idle got %h exp %h", ov(), ex); end
    rst_n = 1'b1;
    tick();
    ex = e(2'b00,1,0,1,0,0,2'b00,4'h0,1,0,0,12'h000);
    checks++; if (ov() !== ex) begin errors++; $display("FAIL add_inf got %h exp %h", ov(), ex); end
    tick();
    ex = e(2'b01,0,1,0,0,0,2'b00,4'b0010,1,0,0,12'b0001_0010_0011);
    checks++; if (ov() !== ex) begin errors++; $display("FAIL add_ex0 got %h exp %h", ov(), ex); end
    tick();
    ex = e(2'b00,1,0,1,0,0,2'b00,4'h0,1,0,0,12'h000);
    checks++; if (ov() !== ex) begin errors++; $display("FAIL add_back_inf got %h exp %h", ov(), ex); end
  endtask

  task automatic test_alu_imm();
    ins_in = mk(7'h10, 3'd6, 3'd0, 3'd5);
    tick();
    ex = e(2'b01,0,1,0,1,0,2'b00,4'b1100,1,0,0,rsf(3'd6,3'd0,3'd5));
    checks++; if (ov() !== ex) begin errors++; $display("FAIL ldi got %h exp %h", ov(), ex); end
    tick(); ins_in = mk(7'h0B, 3'd7, 3'd3, 3'd1);
    tick();
    ex = e(2'b01,0,1,0,0,0,2'b00,4'hB,1,0,0,rsf(3'd7,3'd3,3'd1));
    checks++; if (ov() !== ex) begin errors++; $display("FAIL alu_0b got %h exp %h", ov(), ex); end
    tick();
  endtask

  task automatic test_mem_wait();
    ins_in = mk(7'h12, 3'd3, 3'd4, 3'd0); mem_rdy_in = 0;
    tick();
    for (int i = 0; i < 3; i++) begin
      ex = e(2'b00,0,0,0,0,0,2'b01,4'h0,1,0,0,rsf(3'd3,3'd4,3'd0));
      checks++; if (ov() !== ex) begin errors++; $display("FAIL ld_wait%0d got %h exp %h", i, ov(), ex); end
      tick();
    end
    mem_rdy_in = 1; #1;
    ex = e(2'b01,0,1,0,0,0,2'b01,4'h0,1,0,0,rsf(3'd3,3'd4,3'd0));
    checks++; if (ov() !== ex) begin errors++; $display("FAIL ld_done got %h exp %h", ov(), ex); end
    tick();
    checks++; if (il_out !== 1'b1) begin errors++; $display("FAIL ld_inf got %b exp 1", il_out); end
    ins_in = mk(7'h13, 3'd1, 3'd2, 3'd0); mem_rdy_in = 0;
    tick();
    ex = e(2'b00,0,0,0,0,0,2'b00,4'h0,1,0,0,rsf(3'd1,3'd2,3'd0));
    checks++; if (ov() !== ex) begin errors++; $display("FAIL st_wait got %h exp %h", ov(), ex); end
    mem_rdy_in = 1; #1;
    ex = e(2'b01,0,0,0,0,0,2'b00,4'h0,0,0,0,rsf(3'd1,3'd2,3'd0));
    checks++; if (ov() !== ex) begin errors++; $display("FAIL st_done got %h exp %h", ov(), ex); end
    tick(); ins_in = mk(7'h17, 3'd5, 3'd0, 3'd0); mem_rdy_in = 0;
    tick();
    ex = e(2'b00,0,0,0,0,1,2'b10,4'h0,1,0,0,rsf(3'd5,3'd0,3'd0));
    checks++; if (ov() !== ex) begin errors++; $display("FAIL ior_wait got %h exp %h", ov(), ex); end
    mem_rdy_in = 1; #1;
    ex = e(2'b01,0,1,0,0,1,2'b10,4'h0,1,0,0,rsf(3'd5,3'd0,3'd0));
    checks++; if (ov() !== ex) begin errors++; $display("FAIL ior_done got %h exp %h", ov(), ex); end
    tick(); ins_in = mk(7'h18, 3'd0, 3'd2, 3'd0);
    tick();
    ex = e(2'b01,0,0,0,0,1,2'b00,4'h0,0,0,0,rsf(3'd0,3'd2,3'd0));
    checks++; if (ov() !== ex) begin errors++; $display("FAIL iow got %h exp %h", ov(), ex); end
    tick();
  endtask

  task automatic test_shift();
    ins_in = mk(7'h19, 3'd4, 3'd5, 3'd3);
    tick();
    ex = e(2'b00,0,1,0,0,0,2'b00,4'b1110,1,0,0,rsf(3'd4,3'd5,3'd3));
    checks++; if (ov() !== ex) begin errors++; $display("FAIL shln_ex0 got %h exp %h", ov(), ex); end
    tick();
    ex = e(2'b00,0,1,0,0,0,2'b00,4'b1110,1,0,0,12'b0100_0100_0000);
    checks++; if (ov() !== ex) begin errors++; $display("FAIL shln_xlp1 got %h exp %h", ov(), ex); end
    tick();
    ex = e(2'b01,0,1,0,0,0,2'b00,4'b1110,1,0,0,12'b0100_0100_0000);
    checks++; if (ov() !== ex) begin errors++; $display("FAIL shln_xlp2 got %h exp %h", ov(), ex); end
    tick();
    ex = e(2'b00,1,0,1,0,0,2'b00,4'h0,1,0,0,12'h000);
    checks++; if (ov() !== ex) begin errors++; $display("FAIL shln_inf got %h exp %h", ov(), ex); end
    ins_in = mk(7'h1A, 3'd4, 3'd5, 3'd0);
    tick();
    checks++; if ({rw_out, ps_out} !== 3'b001) begin errors++; $display("FAIL shrn_ba0 got %b exp 001", {rw_out, ps_out}); end
    tick(); ins_in = mk(7'h1A, 3'd2, 3'd1, 3'd1);
    tick();
    ex = e(2'b01,0,1,0,0,0,2'b00,4'b1101,1,0,0,rsf(3'd2,3'd1,3'd1));
    checks++; if (ov() !== ex) begin errors++; $display("FAIL shrn_ba1 got %h exp %h", ov(), ex); end
    tick();
    checks++; if (il_out !== 1'b1) begin errors++; $display("FAIL shrn_ba1_inf got %b exp 1", il_out); end
  endtask

  task automatic test_branch();
    ins_in = mk(7'h14, 3'd1, 3'd1, 3'd1); z_in = 1; n_in = 0;
    tick();
    ex = e(2'b10,0,0,0,0,0,2'b01,4'h0,1,0,0,rsf(3'd1,3'd1,3'd1));
    checks++; if (ov() !== ex) begin errors++; $display("FAIL brz_taken got %h exp %h", ov(), ex); end
    z_in = 0; n_in = 1; #1;
    checks++; if (ps_out !== 2'b01) begin errors++; $display("FAIL brz_not got %b exp 01", ps_out); end
    tick(); ins_in = mk(7'h15, 3'd2, 3'd3, 3'd4);
    tick();
    ex = e(2'b10,0,0,0,0,0,2'b01,4'h0,1,0,0,rsf(3'd2,3'd3,3'd4));
    checks++; if (ov() !== ex) begin errors++; $display("FAIL brn_taken got %h exp %h", ov(), ex); end
    n_in = 0; z_in = 1; #1;
    checks++; if (ps_out !== 2'b01) begin errors++; $display("FAIL brn_not got %b exp 01", ps_out); end
    z_in = 0;
    tick(); ins_in = mk(7'h16, 3'd0, 3'd6, 3'd0);
    tick();
    ex = e(2'b11,0,0,0,0,0,2'b00,4'h0,1,0,0,rsf(3'd0,3'd6,3'd0));
    checks++; if (ov() !== ex) begin errors++; $display("FAIL jmp got %h exp %h", ov(), ex); end
    tick();
  endtask

  task automatic test_halt();
    ins_in = mk(7'h1B, 3'd0, 3'd0, 3'd0); run_in = 0;
    tick();
    checks++; if (ps_out !== 2'b01) begin errors++; $display("FAIL hal_ex0 got %b exp 01", ps_out); end
    for (int i = 0; i < 5; i++) begin
      tick();
      z_in = i[0]; mem_rdy_in = i[1];
      ex = e(2'b00,0,0,0,0,0,2'b00,4'h0,1,1,0,12'h000);
      checks++; if (ov() !== ex) begin errors++; $display("FAIL hlt_hold%0d got %h exp %h", i, ov(), ex); end
    end
    z_in = 0; mem_rdy_in = 1; run_in = 1;
    tick(); run_in = 0;
    ex = e(2'b00,1,0,1,0,0,2'b00,4'h0,1,0,0,12'h000);
    checks++; if (ov() !== ex) begin errors++; $display("FAIL hlt_resume got %h exp %h", ov(), ex); end
  endtask

  task automatic test_illegal();
    ins_in = mk(7'h7F, 3'd7, 3'd7, 3'd7);
    tick();
    ex = e(2'b01,0,0,0,0,0,2'b00,4'h0,1,0,1,rsf(3'd7,3'd7,3'd7));
    checks++; if (ov() !== ex) begin errors++; $display("FAIL illegal_7f got %h exp %h", ov(), ex); end
    tick();
    checks++; if ({il_out, illegal_out} !== 2'b10) begin errors++; $display("FAIL illegal_clear got %b exp 10", {il_out, illegal_out}); end
    ins_in = mk(7'h1C, 3'd0, 3'd0, 3'd0);
    tick();
    checks++; if ({illegal_out, ps_out} !== 3'b101) begin errors++; $display("FAIL illegal_1c got %b exp 101", {illegal_out, ps_out}); end
    tick();
  endtask

  task automatic test_reset_xlp();
    ins_in = mk(7'h19, 3'd3, 3'd2, 3'd7);
    tick(); tick(); tick();
    checks++; if ({rw_out, ps_out, rs_out} !== {1'b1, 2'b00, 12'b0011_0011_0000}) begin
      errors++; $display("FAIL xlp_pre got %h exp %h", {rw_out, ps_out, rs_out}, {1'b1, 2'b00, 12'b0011_0011_0000}); end
    #2 rst_n = 0; #1;
    ex = e(2'b00,0,0,0,0,0,2'b00,4'h0,1,0,0,12'h000);
    checks++; if (ov() !== ex) begin errors++; $display("FAIL rst_async got %h exp %h", ov(), ex); end
    tick();
    rst_n = 1;
    tick();
    checks++; if (il_out !== 1'b1) begin errors++; $display("FAIL rst_restart got %b exp 1", il_out); end
    tick();
    checks++; if ({rw_out, ps_out} !== 3'b100) begin errors++; $display("FAIL ba7_ex0 got %b exp 100", {rw_out, ps_out}); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if ({rw_out, ps_out} !== ((i == 5) ? 3'b101 : 3'b100)) begin
        errors++; $display("FAIL ba7_xlp%0d got %b exp %b", i, {rw_out, ps_out}, (i == 5) ? 3'b101 : 3'b100); end
    end
    tick();
    checks++; if (il_out !== 1'b1) begin errors++; $display("FAIL ba7_inf got %b exp 1", il_out); end
  endtask

  initial begin
    test_reset();
    test_alu_imm();
    test_mem_wait();
    test_shift();
    test_branch();
    test_halt();
    test_illegal();
    test_reset_xlp();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule
